// File: rtl/run_sequencer.sv
// run_sequencer: drives a datapath through NUM_RUNS iterations of
// (hold reset for RST_CYCLES, run for up to RUN_CYCLES), with optional
// early run termination when the datapath PC matches a halt address.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        begin a sequence (honoured in idle/done only)
//   abort_i        return to idle from any state
//   halt_en_i      enable PC-match run termination
//   halt_addr_i    PC value that ends a run early
//   pc_result_i    current PC of the controlled datapath
//   core_rst_o     registered active-high reset to the datapath
//   running_o      high while a run phase is active
//   done_o         high once all runs have completed
//   halt_hit_o     sticky flag: some run ended on a PC match
//   run_idx_o      zero-based index of the current/last run
//   cycle_count_o  cycles elapsed in the current run
module run_sequencer #(
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned RUN_CYCLES = 4,
  parameter int unsigned NUM_RUNS   = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PC_W       = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic                           halt_en_i,
  input  logic [PC_W-1:0]                halt_addr_i,
  input  logic [PC_W-1:0]                pc_result_i,
  output logic                           core_rst_o,
  output logic                           running_o,
  output logic                           done_o,
  output logic                           halt_hit_o,
  output logic [$clog2(NUM_RUNS+1)-1:0]  run_idx_o,
  output logic [CNT_W-1:0]               cycle_count_o
);

  localparam int unsigned IdxW = $clog2(NUM_RUNS + 1);
  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [RstW-1:0]  RstLast = RstW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RunLast = CNT_W'(RUN_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(NUM_RUNS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReset,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              hit_q, hit_d;
  logic              core_rst_q, core_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic              pc_match;
  logic              run_last;

  assign pc_match = halt_en_i && (pc_result_i == halt_addr_i);
  assign run_last = (cnt_q == RunLast);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hit_d     = hit_q;

    if (abort_i) begin
      // Abort beats everything, including a simultaneous start; counters hold.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_d   = StReset;
            rst_cnt_d = '0;
            idx_d     = '0;
            hit_d     = 1'b0;
          end
        end
        StReset: begin
          if (rst_cnt_q == RstLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (pc_match || run_last) begin
            // Limit and PC match together still give a single run end.
            if (pc_match) begin
              hit_d = 1'b1;
            end
            if (idx_q == IdxLast) begin
              state_d = StDone;
            end else begin
              state_d   = StReset;
              idx_d     = idx_q + 1'b1;
              rst_cnt_d = '0;
            end
          end else begin
            // run_last ends the run, so the count never wraps.
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are computed from the next state so they come straight off flops.
    core_rst_d = (state_d != StRun);
    running_d  = (state_d == StRun);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rst_cnt_q  <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign core_rst_o    = core_rst_q;
  assign running_o     = running_q;
  assign done_o        = done_q;
  assign halt_hit_o    = hit_q;
  assign run_idx_o     = idx_q;
  assign cycle_count_o = cnt_q;

endmodule
